// File: rtl/weyl_stream_if.sv
// Quota-in / bitstream-out handshake bundle for weyl_stream_gen.
// A transfer happens on a channel exactly when valid and ready are both high at a rising clock edge.
// Once valid is raised, the payload is held stable until that transfer occurs.
interface weyl_stream_if #(
  parameter int LANES = 4,
  parameter int QW    = 7
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*QW-1:0]   in_quota;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0]      out_bits;
  logic                  out_last;

  modport master (
    output in_valid, in_quota, out_ready,
    input  in_ready, out_valid, out_bits, out_last
  );

  modport slave (
    input  in_valid, in_quota, out_ready,
    output in_ready, out_valid, out_bits, out_last
  );
endinterface

// File: rtl/weyl_stream_gen.sv
// Multi-lane serial Weyl-permuted thermometer bitstream generator with output backpressure.
// Optional WEYL_SEED_ROTATE_EN advances the frame phase by one table position per frame.
module weyl_stream_gen #(
  parameter int BITSTREAM = 64,
  parameter int LANES     = 4,
  parameter int BASE      = 61,
  parameter int STRIDE    = 17
) (
  input  logic           clk,
  input  logic           rst,
  weyl_stream_if.slave   strm,
  output logic           busy
);

  function automatic int inv_mod(input int s, input int n);
    int r;
    r = 0;
    for (int x = 1; x < n; x++) begin
      if ((r == 0) && (((s * x) % n) == 1)) r = x;
    end
    return r;
  endfunction

  localparam int TW   = $clog2(BITSTREAM);
  localparam int QW   = TW + 1;
  localparam int SINV = inv_mod(STRIDE % BITSTREAM, BITSTREAM);
  localparam int J0   = (BITSTREAM - ((BASE * SINV) % BITSTREAM)) % BITSTREAM;

  localparam logic [TW-1:0] SINV_W = TW'(SINV);
  localparam logic [TW-1:0] J0_W   = TW'(J0);
  localparam logic [TW-1:0] T_LAST = TW'(BITSTREAM - 1);
  localparam logic [QW-1:0] N_Q    = QW'(BITSTREAM);

  if ((STRIDE % 2) == 0) begin : g_bad_stride
    $error("weyl_stream_gen: STRIDE must be odd");
  end
  if ((BITSTREAM < 4) || ((1 << TW) != BITSTREAM)) begin : g_bad_len
    $error("weyl_stream_gen: BITSTREAM must be a power of two >= 4");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  logic [TW-1:0]   t;
  logic [TW-1:0]   j;
  logic [QW-1:0]   quota [LANES];
  logic [QW-1:0]   sat_q [LANES];
  logic [TW-1:0]   start_j;
  logic            last;
  logic            beat;
  logic            accept;
  logic            ready_int;
  logic [LANES-1:0] bits;

`ifdef WEYL_SEED_ROTATE_EN
  // Holds -(BASE + r)*SINV mod N for the next frame, so r itself needs no register.
  logic [TW-1:0]   j0_reg;
  assign start_j = j0_reg;
`else
  assign start_j = J0_W;
`endif

  assign busy      = (state == RUN);
  assign last      = busy && (t == T_LAST);
  assign beat      = busy && strm.out_ready;
  assign ready_int = !busy || (last && strm.out_ready);
  assign accept    = strm.in_valid && ready_int;

  assign strm.in_ready  = ready_int;
  assign strm.out_valid = busy;
  assign strm.out_last  = last;
  assign strm.out_bits  = bits;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      sat_q[k] = (strm.in_quota[k*QW +: QW] > N_Q) ? N_Q : strm.in_quota[k*QW +: QW];
    end
  end

  // Slot t carries table position t, whose Weyl index is j; the lane bit is the thermometer test.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      bits[k] = busy && ({1'b0, j} < quota[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t     <= '0;
      j     <= '0;
      for (int k = 0; k < LANES; k++) quota[k] <= '0;
`ifdef WEYL_SEED_ROTATE_EN
      j0_reg <= J0_W;
`endif
    end else begin
      if (accept) begin
        state <= RUN;
        t     <= '0;
        j     <= start_j;
        for (int k = 0; k < LANES; k++) quota[k] <= sat_q[k];
`ifdef WEYL_SEED_ROTATE_EN
        j0_reg <= j0_reg - SINV_W;
`endif
      end else if (beat) begin
        if (last) state <= IDLE;
        t <= t + 1'b1;
        j <= j + SINV_W;
      end
    end
  end

endmodule
